// File: rtl/imem_boot_arbiter.sv
// Instruction-memory controller.
// After reset it boot-loads program words from the loader port while the core
// is held off. It then shares the single memory read port between core fetch
// and debug reads. A starvation guard stops a continuous fetch stream from
// locking out debug forever.
module imem_boot_arbiter #(
  parameter int ADDR_W     = 10,
  parameter bit BOOT_LOAD  = 1'b1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_misalign,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              core_run,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow
);

  // Sized so the counter can reach STARVE_MAX, and also works when STARVE_MAX is 0.
  localparam int CNT_W = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;        // words written; low bits are the write pointer
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              err_q, err_d;
  logic              fv_q, fv_d;
  logic [31:0]       fi_q, fi_d;
  logic              fm_q, fm_d;
  logic              ack_q, ack_d;
  logic [31:0]       dr_q, dr_d;

  logic dbg_live;
  logic starve_hit;
  logic fetch_gnt;
  logic dbg_gnt;

  // The pc bits above the memory range are deliberately ignored, so the fetch address wraps.
  logic unused_pc_hi;
  assign unused_pc_hi = ^fetch_pc[31:ADDR_W+2];

  // State and response registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT_LOAD ? S_LOAD : S_RUN;
      cnt_q    <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
      fv_q     <= 1'b0;
      fi_q     <= '0;
      fm_q     <= 1'b0;
      ack_q    <= 1'b0;
      dr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fi_q     <= fi_d;
      fm_q     <= fm_d;
      ack_q    <= ack_d;
      dr_q     <= dr_d;
    end
  end

  // Next state, loader write path and read-port arbitration.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    starve_d   = '0;
    fv_d       = 1'b0;
    fi_d       = fi_q;
    fm_d       = 1'b0;
    ack_d      = 1'b0;
    dr_d       = dr_q;
    ld_ready   = 1'b0;
    core_run   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = ld_data;
    dbg_live   = 1'b0;
    starve_hit = 1'b0;
    fetch_gnt  = 1'b0;
    dbg_gnt    = 1'b0;

    if (state_q == S_LOAD) begin
      ld_ready = 1'b1;
      mem_addr = cnt_q[ADDR_W-1:0];
      if (ld_valid) begin
        // Suppress the write while reset is asserted, so a reset aborts the load cleanly.
        mem_we = !rst;
        cnt_d  = cnt_q + 1'b1;
        if (ld_last) begin
          state_d = S_RUN;
        end else if (cnt_q[ADDR_W-1:0] == LAST_ADDR) begin
          // The memory is full. Stop here rather than wrap and overwrite word 0.
          state_d = S_RUN;
          err_d   = 1'b1;
        end
      end
    end else begin
      core_run = 1'b1;
      // A request still held during its own ack cycle has already been served.
      dbg_live   = dbg_req && !ack_q;
      starve_hit = dbg_live && (starve_q == STARVE_LIM);
      fetch_gnt  = fetch_req && !starve_hit;
      dbg_gnt    = dbg_live && !fetch_gnt;
      if (fetch_gnt) begin
        mem_addr = fetch_pc[ADDR_W+1:2];
        fi_d     = mem_rdata;
      end else if (dbg_gnt) begin
        mem_addr = dbg_addr;
        dr_d     = mem_rdata;
      end
      if (dbg_live && !dbg_gnt) begin
        starve_d = starve_q + 1'b1;
      end
      fv_d  = fetch_gnt;
      fm_d  = fetch_gnt && (fetch_pc[1:0] != 2'b00);
      ack_d = dbg_gnt;
    end
  end

  assign fetch_valid    = fv_q;
  assign fetch_instr    = fi_q;
  assign fetch_misalign = fm_q;
  assign dbg_ack        = ack_q;
  assign dbg_rdata      = dr_q;
  assign load_count     = cnt_q;
  assign err_overflow   = err_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Bench for imem_boot_arbiter. A behavioural model of the loader and the read-port
// sharing is compared against the DUT on every cycle. Directed sequences add
// literal expectations.
module tb_imem_boot_arbiter;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic          rst, ld_valid, ld_last, fetch_req, dbg_req;
  logic [31:0]   ld_data, fetch_pc, mem_rdata, mem_wdata, fetch_instr, dbg_rdata;
  logic [AW-1:0] dbg_addr, mem_addr;
  logic          ld_ready, mem_we, fetch_valid, fetch_misalign, dbg_ack, core_run, err_overflow;
  logic [AW:0]   load_count;

  // small-memory DUT signals (overflow boundary)
  logic        s_rst, s_ld_valid, s_ld_last, s_ld_ready, s_mem_we, s_fv, s_fm, s_ack, s_run, s_err;
  logic [31:0] s_ld_data, s_wdata, s_fi, s_dr;
  logic [1:0]  s_mem_addr;
  logic [2:0]  s_load_count;

  // DUT that boots straight into RUN
  logic        z_ld_ready, z_mem_we, z_fv, z_fm, z_ack, z_run, z_err;
  logic [31:0] z_wdata, z_fi, z_dr;
  logic [3:0]  z_mem_addr;
  logic [4:0]  z_load_count;

  logic [31:0] env_mem [0:DEPTH-1];
  assign mem_rdata = env_mem[mem_addr];

  imem_boot_arbiter #(.ADDR_W(AW), .BOOT_LOAD(1'b1), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_misalign(fetch_misalign),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .core_run(core_run), .load_count(load_count), .err_overflow(err_overflow));

  imem_boot_arbiter #(.ADDR_W(2), .BOOT_LOAD(1'b1), .STARVE_MAX(SMAX)) u_small (
    .clk(clk), .rst(s_rst), .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last),
    .ld_ready(s_ld_ready), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_wdata),
    .mem_rdata(32'h0), .fetch_req(1'b0), .fetch_pc(32'h0),
    .fetch_valid(s_fv), .fetch_instr(s_fi), .fetch_misalign(s_fm),
    .dbg_req(1'b0), .dbg_addr(2'b00), .dbg_ack(s_ack), .dbg_rdata(s_dr),
    .core_run(s_run), .load_count(s_load_count), .err_overflow(s_err));

  imem_boot_arbiter #(.ADDR_W(4), .BOOT_LOAD(1'b0), .STARVE_MAX(SMAX)) u_noboot (
    .clk(clk), .rst(rst), .ld_valid(1'b1), .ld_data(32'hFFFF_FFFF), .ld_last(1'b0),
    .ld_ready(z_ld_ready), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_wdata),
    .mem_rdata(32'h0), .fetch_req(1'b0), .fetch_pc(32'h0),
    .fetch_valid(z_fv), .fetch_instr(z_fi), .fetch_misalign(z_fm),
    .dbg_req(1'b0), .dbg_addr(4'h0), .dbg_ack(z_ack), .dbg_rdata(z_dr),
    .core_run(z_run), .load_count(z_load_count), .err_overflow(z_err));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [0:DEPTH-1];
  bit          mem_ready = 1'b0;
  bit          m_init = 1'b0;
  bit          m_load;
  bit          m_err;
  int          m_cnt;
  int          m_wait;     // consecutive cycles a live debug request lost to fetch
  int          n_wr = 0;   // writes observed on the main DUT
  bit          e_fv, e_fm, e_ack;
  logic [31:0] e_fi, e_dr;
  bit          live, fgnt, dgnt;
  int          word;

  // Per-cycle comparison. Inputs are stable at the falling edge, and the
  // registered outputs reflect the decision taken at the previous rising edge.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) begin
        env_mem[i] = $urandom;
        m_mem[i]   = env_mem[i];
      end
      mem_ready = 1'b1;
    end
    if (m_init) begin
      chk("fetch_valid", 64'(fetch_valid), 64'(e_fv));
      if (e_fv) chk("fetch_instr", 64'(fetch_instr), 64'(e_fi));
      chk("fetch_misalign", 64'(fetch_misalign), 64'(e_fm));
      chk("dbg_ack", 64'(dbg_ack), 64'(e_ack));
      if (e_ack) chk("dbg_rdata", 64'(dbg_rdata), 64'(e_dr));
      chk("load_count", 64'(load_count), 64'(m_cnt));
      chk("err_overflow", 64'(err_overflow), 64'(m_err));
      chk("core_run", 64'(core_run), 64'(!m_load));
      chk("ld_ready", 64'(ld_ready), 64'(m_load));
    end
    if (rst) begin
      m_init = 1'b1; m_load = 1'b1; m_err = 1'b0; m_cnt = 0; m_wait = 0;
      e_fv = 1'b0; e_fm = 1'b0; e_ack = 1'b0;
    end else if (m_init) begin
      if (m_load) begin
        chk("mem_we", 64'(mem_we), 64'(ld_valid));
        if (ld_valid) begin
          chk("wr_addr", 64'(mem_addr), 64'(m_cnt));
          chk("wr_data", 64'(mem_wdata), 64'(ld_data));
          m_mem[m_cnt] = ld_data;
          m_cnt++;
          if (ld_last) m_load = 1'b0;
          else if (m_cnt == DEPTH) begin m_load = 1'b0; m_err = 1'b1; end
        end
        e_fv = 1'b0; e_fm = 1'b0; e_ack = 1'b0;
      end else begin
        chk("mem_we_run", 64'(mem_we), 64'(0));
        live = dbg_req && !e_ack;
        fgnt = fetch_req && !(live && m_wait >= SMAX);
        dgnt = live && !fgnt;
        word = int'(fetch_pc >> 2) % DEPTH;
        if (fgnt)      chk("fetch_addr", 64'(mem_addr), 64'(word));
        else if (dgnt) chk("dbg_addr", 64'(mem_addr), 64'(dbg_addr));
        else           chk("idle_addr", 64'(mem_addr), 64'(0));
        e_fv = fgnt;
        e_fm = fgnt && ((fetch_pc % 4) != 0);
        if (fgnt) e_fi = m_mem[word];
        e_ack = dgnt;
        if (dgnt) e_dr = m_mem[dbg_addr];
        m_wait = (live && !dgnt) ? m_wait + 1 : 0;
      end
    end
    if (mem_we) begin
      env_mem[mem_addr] = mem_wdata;
      n_wr++;
    end
  end

  // Record the write addresses of the small DUT.
  int         s_wr = 0;
  logic [1:0] s_wa [0:7];
  always @(negedge clk) begin
    if (!s_rst && s_mem_we) begin
      if (s_wr < 8) s_wa[s_wr] = s_mem_addr;
      s_wr++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input bit last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    $display("txn load data=0x%08h last=%0d load_count=%0d", d, last, load_count);
  endtask

  task automatic run_traffic(input int n);
    int waited = 0;
    for (int c = 0; c < n; c++) begin
      fetch_req = ($urandom_range(0, 3) != 0);
      fetch_pc  = $urandom;
      if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1; dbg_addr = AW'($urandom);
      end
      tick();
      if (dbg_req && dbg_ack) begin
        waited   = 0;
        dbg_req  = ($urandom_range(0, 1) == 1);
        dbg_addr = AW'($urandom);
      end else if (dbg_req) begin
        waited++;
        if (waited > SMAX + 3) begin
          chk("dbg_wait_bound", 64'(waited), 64'(0));
          dbg_req = 1'b0; waited = 0;
        end
      end
    end
    fetch_req = 1'b0; dbg_req = 1'b0;
    tick();
  endtask

  initial begin
    int w0, nw;
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    fetch_req = 1'b0; fetch_pc = '0; dbg_req = 1'b0; dbg_addr = '0;
    s_rst = 1'b1; s_ld_valid = 1'b0; s_ld_last = 1'b0; s_ld_data = '0;

    // Reset state
    do_reset();
    chk("rst_core_run", 64'(core_run), 64'(0));
    chk("rst_ld_ready", 64'(ld_ready), 64'(1));
    chk("rst_load_count", 64'(load_count), 64'(0));
    chk("noboot_core_run", 64'(z_run), 64'(1));
    chk("noboot_ld_ready", 64'(z_ld_ready), 64'(0));
    tick();
    chk("noboot_no_write", 64'(z_mem_we), 64'(0));
    chk("noboot_load_count", 64'(z_load_count), 64'(0));

    // Boot load of three words
    push(32'h0062E233, 1'b0);
    push(32'h0064A423, 1'b0);
    chk("boot_run_before_last", 64'(core_run), 64'(0));
    push(32'h00832383, 1'b1);
    chk("boot_core_run", 64'(core_run), 64'(1));
    chk("boot_load_count", 64'(load_count), 64'(3));

    // Aligned fetch of word 2
    fetch_req = 1'b1; fetch_pc = 32'h8;
    tick();
    fetch_req = 1'b0;
    $display("txn fetch pc=0x8 valid=%0d instr=0x%08h", fetch_valid, fetch_instr);
    chk("fetch8_valid", 64'(fetch_valid), 64'(1));
    chk("fetch8_instr", 64'(fetch_instr), 64'h00832383);

    // Misaligned fetch reads word 1 and flags it for one cycle
    fetch_req = 1'b1; fetch_pc = 32'h6;
    tick();
    fetch_req = 1'b0;
    $display("txn fetch pc=0x6 instr=0x%08h misalign=%0d", fetch_instr, fetch_misalign);
    chk("mis_instr", 64'(fetch_instr), 64'h0064A423);
    chk("mis_flag", 64'(fetch_misalign), 64'(1));
    tick();
    chk("mis_pulse_end", 64'(fetch_misalign), 64'(0));

    // Contention: fetch wins four cycles, then debug is forced through
    fetch_req = 1'b1; fetch_pc = 32'h0; dbg_req = 1'b1; dbg_addr = 10'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) begin
        chk("cont_fetch_valid", 64'(fetch_valid), 64'(1));
        chk("cont_no_ack", 64'(dbg_ack), 64'(0));
      end else begin
        chk("cont_fetch_blocked", 64'(fetch_valid), 64'(0));
        chk("cont_ack", 64'(dbg_ack), 64'(1));
        chk("cont_rdata", 64'(dbg_rdata), 64'h0064A423);
      end
    end
    dbg_req = 1'b0; fetch_req = 1'b0;
    $display("txn debug addr=1 ack after starvation, rdata=0x%08h", dbg_rdata);
    tick();
    chk("cont_ack_pulse", 64'(dbg_ack), 64'(0));

    // Loader with gaps: valid pattern 1,0,0,1(last)
    do_reset();
    w0 = n_wr;
    push(32'hA5A5_0001, 1'b0);
    tick();
    tick();
    push(32'hA5A5_0002, 1'b1);
    chk("stall_writes", 64'(n_wr - w0), 64'(2));
    chk("stall_load_count", 64'(load_count), 64'(2));
    chk("stall_run", 64'(core_run), 64'(1));

    // Random loads followed by random fetch/debug traffic
    for (int it = 0; it < 6; it++) begin
      do_reset();
      nw = $urandom_range(1, 40);
      for (int i = 0; i < nw; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          fetch_req = $urandom_range(0, 1) == 1; fetch_pc = $urandom;
          tick();
        end
        fetch_req = $urandom_range(0, 1) == 1;
        push($urandom, i == nw - 1);
      end
      fetch_req = 1'b0;
      run_traffic(400);
    end

    // Fill the whole memory without ld_last; one extra word must be refused
    do_reset();
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      ld_data = $urandom;
      tick();
    end
    ld_valid = 1'b0;
    $display("txn overflow load_count=%0d err=%0d", load_count, err_overflow);
    chk("ovf_load_count", 64'(load_count), 64'(DEPTH));
    chk("ovf_err", 64'(err_overflow), 64'(1));
    chk("ovf_run", 64'(core_run), 64'(1));
    run_traffic(200);

    // Reset mid-load, then reload one word; fetches during LOAD are ignored
    do_reset();
    push(32'h1111_1111, 1'b0);
    push(32'h2222_2222, 1'b0);
    do_reset();
    chk("midrst_err_clear", 64'(err_overflow), 64'(0));
    fetch_req = 1'b1; fetch_pc = 32'h4;
    tick();
    chk("load_no_fetch", 64'(fetch_valid), 64'(0));
    fetch_req = 1'b0;
    push(32'h3333_3333, 1'b1);
    chk("midrst_load_count", 64'(load_count), 64'(1));
    chk("midrst_err", 64'(err_overflow), 64'(0));
    fetch_req = 1'b1; fetch_pc = 32'h0;
    tick();
    fetch_req = 1'b0;
    chk("midrst_word0", 64'(fetch_instr), 64'h3333_3333);

    // Overflow boundary on a 4-word memory
    tick();
    s_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_ld_valid = 1'b1; s_ld_data = 32'(i);
      chk("small_ld_ready", 64'(s_ld_ready), 64'(i < 4));
      tick();
    end
    s_ld_valid = 1'b0;
    tick();
    $display("txn small overflow writes=%0d err=%0d", s_wr, s_err);
    chk("small_writes", 64'(s_wr), 64'(4));
    for (int i = 0; i < 4; i++) chk("small_wr_addr", 64'(s_wa[i]), 64'(i));
    chk("small_err", 64'(s_err), 64'(1));
    chk("small_run", 64'(s_run), 64'(1));
    chk("small_load_count", 64'(s_load_count), 64'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_boot_arbiter.md
Name: imem_boot_arbiter

Overview:
- Controls the single-port, word-organised instruction memory (1024 x 32, combinational read, word index = byte address[31:2]).
- After reset, runs a boot-load phase that streams program words from a loader port into the memory while the core is held stalled.
- Then releases the core and shares the memory read port between core instruction fetch and a debug read port, with a starvation guard.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory (depth = 2**ADDR_W).
- BOOT_LOAD, 1, 1 = enter LOAD after reset; 0 = go directly to RUN.
- STARVE_MAX, 4, consecutive cycles dbg_req may be blocked by fetch before debug is forced a grant.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  marks final loader word; qualified by ld_valid.
- ld_ready  out  1  controller accepts loader word this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  instruction-memory word address.
- mem_wdata  out  32  instruction-memory write data.
- mem_rdata  in  32  instruction-memory combinational read data.
- fetch_req  in  1  core fetch request.
- fetch_pc  in  32  byte address of fetch.
- fetch_valid  out  1  registered; fetch_instr valid.
- fetch_instr  out  32  registered fetched word.
- fetch_misalign  out  1  registered pulse; granted fetch had fetch_pc[1:0] != 0.
- dbg_req  in  1  debug read request, held until dbg_ack.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_ack  out  1  registered one-cycle acknowledge.
- dbg_rdata  out  32  registered debug read data, valid with dbg_ack.
- core_run  out  1  high only in RUN; core must not fetch while low.
- load_count  out  ADDR_W+1  number of words written during LOAD.
- err_overflow  out  1  sticky; loader exceeded memory depth.

Behaviour:
- States:
  - LOAD: ld_ready=1, core_run=0.
  - RUN: ld_ready=0, core_run=1.
- Reset:
  - state = LOAD if BOOT_LOAD=1, else RUN.
  - All registered outputs = 0; write pointer = 0; starvation counter = 0.
  - Reset asserted mid-load aborts the load: memory contents are kept, but the pointer and load_count restart at 0.
- LOAD:
  - Each cycle with ld_valid=1 writes one word: mem_we=1, mem_addr=wptr, mem_wdata=ld_data (all combinational); wptr and load_count then increment.
  - ld_valid with ld_last=1: the word is written, then state goes to RUN on the next edge.
  - A write at wptr=2**ADDR_W-1 without ld_last: the word is written, err_overflow sets, state goes to RUN; wptr does not wrap.
  - fetch_req and dbg_req are ignored in LOAD; fetch_valid=0, dbg_ack=0.
- RUN:
  - mem_we=0 always; ld_valid is ignored.
  - Arbitration, one grant per cycle:
    - fetch_req only: fetch granted.
    - dbg_req only: debug granted.
    - Both: fetch granted unless starve_cnt == STARVE_MAX, in which case debug is granted.
  - Starvation counter: increments on each cycle dbg_req is high and not granted; clears on a debug grant or when dbg_req is low.
  - Debug request handling: dbg_req is not re-evaluated in the cycle dbg_ack is high, which prevents a double grant of a held request.
  - Grant to fetch: mem_addr = fetch_pc[ADDR_W+1:2]. Next cycle: fetch_valid=1, fetch_instr=mem_rdata, fetch_misalign = |fetch_pc[1:0]. Upper pc bits beyond ADDR_W+1 are ignored (wrap).
  - Fetch not granted: fetch_valid=0 next cycle, and the core re-presents the request.
  - Grant to debug: mem_addr = dbg_addr; next cycle dbg_ack=1, dbg_rdata=mem_rdata.
  - Idle: mem_addr = 0.
- Latency: read responses arrive 1 cycle after grant; sustained fetch throughput is 1 word/cycle absent debug.
- load_count holds its final value during RUN; err_overflow clears only on rst.

Test Plan:
- Boot load: push 3 words 0x0062E233, 0x0064A423, 0x00832383 with ld_last on the third -> mem writes at addresses 0,1,2; load_count=3; core_run rises the cycle after the third accept; then fetch_pc=0x8 -> fetch_valid next cycle with fetch_instr=0x00832383.
- Loader stalls: ld_valid toggled 1,0,0,1(last) -> exactly 2 writes, at addresses 0 and 1; no write in the gap cycles; load_count=2.
- Overflow with ADDR_W=2: 5 words, no ld_last -> 4 writes (addresses 0..3); err_overflow=1; RUN entered; 5th word not accepted (ld_ready=0).
- Contention, STARVE_MAX=4: fetch_req held high and dbg_req asserted at cycle t -> fetch granted t..t+3, debug granted t+4, dbg_ack at t+5, fetch_valid=0 at t+5.
- Misaligned fetch: fetch_pc=0x00000006 -> fetch_instr=mem[1], fetch_misalign=1 for one cycle.
- Reset mid-load after 2 words, then BOOT_LOAD path reload of 1 word with last -> load_count=1, write at address 0; err_overflow=0; fetch during LOAD produces no fetch_valid.
